// File: rtl/writeback_if.sv
// Writeback-stage bus: M-stage inputs, decode read ports and W/status outputs.
// The pipeline drives through master; the writeback block sits on slave.
interface writeback_if #(
  parameter int unsigned CNT_W = 32
);
  logic             W_stall_i;
  logic             W_bubble_i;
  logic [3:0]       m_stat_i;
  logic [3:0]       M_icode_i;
  logic [63:0]      M_valE_i;
  logic [63:0]      m_valM_i;
  logic [3:0]       M_dstE_i;
  logic [3:0]       M_dstM_i;
  logic [3:0]       srcA_i;
  logic [3:0]       srcB_i;
  logic [63:0]      rvalA_o;
  logic [63:0]      rvalB_o;
  logic [3:0]       W_stat_o;
  logic [3:0]       W_icode_o;
  logic [3:0]       W_dstE_o;
  logic [3:0]       W_dstM_o;
  logic [63:0]      W_valE_o;
  logic [63:0]      W_valM_o;
  logic [3:0]       Stat_o;
  logic             halted_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    output W_stall_i, W_bubble_i, m_stat_i, M_icode_i, M_valE_i, m_valM_i,
           M_dstE_i, M_dstM_i, srcA_i, srcB_i,
    input  rvalA_o, rvalB_o, W_stat_o, W_icode_o, W_dstE_o, W_dstM_o,
           W_valE_o, W_valM_o, Stat_o, halted_o, retired_o
  );

  modport slave (
    input  W_stall_i, W_bubble_i, m_stat_i, M_icode_i, M_valE_i, m_valM_i,
           M_dstE_i, M_dstM_i, srcA_i, srcB_i,
    output rvalA_o, rvalB_o, W_stat_o, W_icode_o, W_dstE_o, W_dstM_o,
           W_valE_o, W_valM_o, Stat_o, halted_o, retired_o
  );
endinterface

// File: rtl/writeback.sv
// Y86-64 writeback stage: W pipeline register, 15x64 register file with
// E/M write ports, sticky RUN/HALT/ERR status FSM and retired-instruction counter.
module writeback #(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  writeback_if.slave  wb
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 15;
  localparam int unsigned FW   = 4;

  localparam logic [FW-1:0] SAOK  = FW'(1);
  localparam logic [FW-1:0] SHLT  = FW'(2);
  localparam logic [FW-1:0] SADR  = FW'(3);
  localparam logic [FW-1:0] SINS  = FW'(4);
  localparam logic [FW-1:0] INOP  = FW'(1);
  localparam logic [FW-1:0] RNONE = FW'(15);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     stat_q, stat_d;
  logic              halted_q, halted_d;

  logic [FW-1:0]     w_stat_q;
  logic [FW-1:0]     w_icode_q;
  logic [FW-1:0]     w_dste_q;
  logic [FW-1:0]     w_dstm_q;
  logic [XLEN-1:0]   w_vale_q;
  logic [XLEN-1:0]   w_valm_q;

  logic [XLEN-1:0]   regs_q [NREG];
  logic [CNT_W-1:0]  retired_q;

  logic running;
  logic wr_en;
  logic retire;

  assign running = (state_q == ST_RUN);
  assign wr_en   = running && (w_stat_q == SAOK);
  // A halting instruction retires on the edge that moves the FSM to HALT.
  assign retire  = running &&
                   (((w_stat_q == SAOK) && (w_icode_q != INOP) && !wb.W_stall_i) ||
                    (w_stat_q == SHLT));

  // Status FSM next state: exceptions latch the W status code and stick.
  always_comb begin
    state_d  = state_q;
    stat_d   = stat_q;
    halted_d = halted_q;
    if (state_q == ST_RUN) begin
      case (w_stat_q)
        SHLT: begin
          state_d  = ST_HALT;
          stat_d   = w_stat_q;
          halted_d = 1'b1;
        end
        SADR, SINS: begin
          state_d  = ST_ERR;
          stat_d   = w_stat_q;
          halted_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      stat_q   <= SAOK;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stat_q   <= stat_d;
      halted_q <= halted_d;
    end
  end

  // W pipeline register; stall beats bubble, and everything freezes off RUN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_stat_q  <= SAOK;
      w_icode_q <= INOP;
      w_dste_q  <= RNONE;
      w_dstm_q  <= RNONE;
      w_vale_q  <= '0;
      w_valm_q  <= '0;
    end else if (running && !wb.W_stall_i) begin
      if (wb.W_bubble_i) begin
        w_stat_q  <= SAOK;
        w_icode_q <= INOP;
        w_dste_q  <= RNONE;
        w_dstm_q  <= RNONE;
        w_vale_q  <= '0;
        w_valm_q  <= '0;
      end else begin
        w_stat_q  <= wb.m_stat_i;
        w_icode_q <= wb.M_icode_i;
        w_dste_q  <= wb.M_dstE_i;
        w_dstm_q  <= wb.M_dstM_i;
        w_vale_q  <= wb.M_valE_i;
        w_valm_q  <= wb.m_valM_i;
      end
    end
  end

  // Register file: port M is written last so it wins on dstE == dstM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      if (w_dste_q != RNONE) begin
        regs_q[w_dste_q] <= w_vale_q;
      end
      if (w_dstm_q != RNONE) begin
        regs_q[w_dstm_q] <= w_valm_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Combinational reads without bypass; decode forwards from the W fields.
  assign wb.rvalA_o = (wb.srcA_i == RNONE) ? '0 : regs_q[wb.srcA_i];
  assign wb.rvalB_o = (wb.srcB_i == RNONE) ? '0 : regs_q[wb.srcB_i];

  assign wb.W_stat_o  = w_stat_q;
  assign wb.W_icode_o = w_icode_q;
  assign wb.W_dstE_o  = w_dste_q;
  assign wb.W_dstM_o  = w_dstm_q;
  assign wb.W_valE_o  = w_vale_q;
  assign wb.W_valM_o  = w_valm_q;
  assign wb.Stat_o    = stat_q;
  assign wb.halted_o  = halted_q;
  assign wb.retired_o = retired_q;

endmodule

// File: tb/tb_writeback.sv
// Directed bench for the writeback stage with a 4-bit retired counter.
module tb_writeback;

  localparam int unsigned CNT_W = 4;

  logic clk_i;
  logic rst_i;
  int   n_tests;
  int   n_fail;

  writeback_if #(.CNT_W(CNT_W)) wb ();

  writeback #(.CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wb    (wb.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_m(input logic [3:0] stat, input logic [3:0] icode,
                        input logic [3:0] dste, input logic [63:0] vale,
                        input logic [3:0] dstm, input logic [63:0] valm);
    wb.m_stat_i  = stat;
    wb.M_icode_i = icode;
    wb.M_dstE_i  = dste;
    wb.M_valE_i  = vale;
    wb.M_dstM_i  = dstm;
    wb.m_valM_i  = valm;
  endtask

  task automatic set_idle();
    load_m(4'd1, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
  endtask

  task automatic read_ab(input logic [3:0] a, input logic [3:0] b);
    wb.srcA_i = a;
    wb.srcB_i = b;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_i = 1'b1;
    wb.W_stall_i  = 1'b0;
    wb.W_bubble_i = 1'b0;
    wb.srcA_i = 4'd0;
    wb.srcB_i = 4'd0;
    set_idle();
    #3;

    // Reset state
    check_eq("rst_stat",    64'(wb.Stat_o), 64'd1);
    check_eq("rst_halted",  64'(wb.halted_o), 64'd0);
    check_eq("rst_retired", 64'(wb.retired_o), 64'd0);
    check_eq("rst_w_icode", 64'(wb.W_icode_o), 64'd1);
    check_eq("rst_w_dste",  64'(wb.W_dstE_o), 64'hF);
    check_eq("rst_rvala",   wb.rvalA_o, 64'd0);
    step();
    rst_i = 1'b0;

    // irrmovq into r3
    load_m(4'd1, 4'd2, 4'd3, 64'h1234, 4'hF, 64'd0);
    step();
    check_eq("w_vale_load", wb.W_valE_o, 64'h1234);
    check_eq("w_icode_load", 64'(wb.W_icode_o), 64'd2);
    set_idle();
    step();
    read_ab(4'd3, 4'hF);
    check_eq("r3_written", wb.rvalA_o, 64'h1234);
    check_eq("retired_1", 64'(wb.retired_o), 64'd1);

    // popq: both ports, then same destination where M wins
    load_m(4'd1, 4'hB, 4'd4, 64'h100, 4'd0, 64'hAB);
    step();
    set_idle();
    step();
    read_ab(4'd4, 4'd0);
    check_eq("pop_r4", wb.rvalA_o, 64'h100);
    check_eq("pop_r0", wb.rvalB_o, 64'hAB);
    load_m(4'd1, 4'hB, 4'd4, 64'h100, 4'd4, 64'h55);
    step();
    set_idle();
    step();
    read_ab(4'd4, 4'hF);
    check_eq("pop_same_dst", wb.rvalA_o, 64'h55);
    check_eq("retired_3", 64'(wb.retired_o), 64'd3);

    // Stall and bubble together hold W; writes repeat, no retirement
    load_m(4'd1, 4'd2, 4'd6, 64'h77, 4'hF, 64'd0);
    step();
    wb.W_stall_i  = 1'b1;
    wb.W_bubble_i = 1'b1;
    load_m(4'd1, 4'd2, 4'd7, 64'h99, 4'hF, 64'd0);
    repeat (3) step();
    read_ab(4'd6, 4'd7);
    check_eq("stall_w_dste", 64'(wb.W_dstE_o), 64'd6);
    check_eq("stall_w_vale", wb.W_valE_o, 64'h77);
    check_eq("stall_r6", wb.rvalA_o, 64'h77);
    check_eq("stall_r7", wb.rvalB_o, 64'd0);
    check_eq("stall_retired", 64'(wb.retired_o), 64'd3);
    wb.W_stall_i = 1'b0;
    step();
    check_eq("bubble_icode", 64'(wb.W_icode_o), 64'd1);
    check_eq("bubble_dste", 64'(wb.W_dstE_o), 64'hF);
    check_eq("bubble_retired", 64'(wb.retired_o), 64'd4);
    wb.W_bubble_i = 1'b0;

    // Halt: sticky, suppresses writes, counts the halt once
    load_m(4'd2, 4'd0, 4'hF, 64'd0, 4'hF, 64'd0);
    step();
    check_eq("pre_halt_halted", 64'(wb.halted_o), 64'd0);
    load_m(4'd1, 4'd2, 4'd5, 64'h55AA, 4'hF, 64'd0);
    step();
    check_eq("halt_stat", 64'(wb.Stat_o), 64'd2);
    check_eq("halt_halted", 64'(wb.halted_o), 64'd1);
    check_eq("halt_retired", 64'(wb.retired_o), 64'd5);
    wb.W_bubble_i = 1'b1;
    repeat (3) step();
    wb.W_bubble_i = 1'b0;
    read_ab(4'd5, 4'hF);
    check_eq("halt_r5_blocked", wb.rvalA_o, 64'd0);
    check_eq("halt_w_frozen", 64'(wb.W_icode_o), 64'd2);
    check_eq("halt_retired_frozen", 64'(wb.retired_o), 64'd5);
    rst_i = 1'b1;
    #1;
    check_eq("async_rst_stat", 64'(wb.Stat_o), 64'd1);
    check_eq("async_rst_halted", 64'(wb.halted_o), 64'd0);
    check_eq("async_rst_retired", 64'(wb.retired_o), 64'd0);
    wb.srcA_i = 4'd3;
    #1;
    check_eq("async_rst_r3", wb.rvalA_o, 64'd0);
    rst_i = 1'b0;

    // Address error: no write, status sticky and not overwritten by SINS
    load_m(4'd3, 4'd2, 4'd2, 64'hDEAD, 4'hF, 64'd0);
    step();
    set_idle();
    step();
    read_ab(4'd2, 4'hF);
    check_eq("err_stat", 64'(wb.Stat_o), 64'd3);
    check_eq("err_r2_blocked", wb.rvalA_o, 64'd0);
    repeat (10) step();
    check_eq("err_sticky", 64'(wb.Stat_o), 64'd3);
    load_m(4'd4, 4'd2, 4'hF, 64'd0, 4'hF, 64'd0);
    repeat (2) step();
    check_eq("err_sins_ignored", 64'(wb.Stat_o), 64'd3);
    check_eq("err_halted", 64'(wb.halted_o), 64'd1);

    // Counter wrap at 2^CNT_W
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_m(4'd1, 4'd2, 4'd8, 64'(i + 1), 4'hF, 64'd0);
      step();
    end
    read_ab(4'd8, 4'hF);
    check_eq("wrap_pre", 64'(wb.retired_o), 64'd15);
    check_eq("wrap_r8", wb.rvalA_o, 64'd15);
    step();
    check_eq("wrap_zero", 64'(wb.retired_o), 64'd0);
    read_ab(4'hF, 4'hF);
    check_eq("rnone_a", wb.rvalA_o, 64'd0);
    check_eq("rnone_b", wb.rvalB_o, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
